// File: rtl/muldiv_sequencer.sv
// Sequences the shared MULT/DIV units and owns the architectural HI/LO registers.
// Optional MULDIV_PERF_EN adds saturating commit and stall counters.
module muldiv_sequencer #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic              op_sel,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hi_wr,
  input  logic              lo_wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  output logic              mult_start,
  input  logic              mult_stop,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  output logic              div_start,
  input  logic              div_stop,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              timeout
`ifdef MULDIV_PERF_EN
  ,
  output logic [15:0]       perf_ops,
  output logic [15:0]       perf_stall
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COMMIT,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] unit_a_q, unit_a_d;
  logic [DATA_W-1:0] unit_b_q, unit_b_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              sel_stop;

  assign sel_stop = sel_q ? div_stop : mult_stop;

  // NOTE: every variable gets its hold/default value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    unit_a_d  = unit_a_q;
    unit_b_d  = unit_b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hi_wr) hi_d = wr_data;
        if (lo_wr) lo_d = wr_data;
        if (op_start) begin
          if (op_sel && (src_b == '0)) begin
            state_d = S_FAULT;
          end else begin
            unit_a_d = src_a;
            unit_b_d = src_b;
            sel_d    = op_sel;
            state_d  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The first WAIT cycle (cnt_q == 0) may still see a stale stop level from the previous op.
        if ((cnt_q != '0) && sel_stop) begin
          hi_d    = sel_q ? div_hi : mult_hi;
          lo_d    = sel_q ? div_lo : mult_lo;
          state_d = S_COMMIT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      S_FAULT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      unit_a_q  <= '0;
      unit_b_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      unit_a_q  <= unit_a_d;
      unit_b_q  <= unit_b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign mult_start = (state_q == S_LAUNCH) && !sel_q;
  assign div_start  = (state_q == S_LAUNCH) && sel_q;
  assign done       = (state_q == S_COMMIT);
  assign div_zero   = (state_q == S_FAULT);

`ifdef MULDIV_PERF_EN
  logic [15:0] perf_ops_q, perf_ops_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (done && (perf_ops_q != 16'hFFFF))     perf_ops_d   = perf_ops_q + 16'd1;
    if (busy_q && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer: behavioural MULT model, hand-driven DIV stub.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start, op_sel, hi_wr, lo_wr;
  logic [31:0] src_a, src_b, wr_data;
  logic [31:0] unit_a, unit_b, hi_out, lo_out;
  logic        mult_start, div_start, busy, done, div_zero, timeout;
  logic        mult_stop = 1'b0;
  logic [31:0] mult_hi = '0, mult_lo = '0;
  logic        div_stop;
  logic [31:0] div_hi, div_lo;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer #(.DATA_W(32), .TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .reset(reset),
    .op_start(op_start), .op_sel(op_sel), .src_a(src_a), .src_b(src_b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .unit_a(unit_a), .unit_b(unit_b),
    .mult_start(mult_start), .mult_stop(mult_stop), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_start(div_start), .div_stop(div_stop), .div_hi(div_hi), .div_lo(div_lo),
    .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // MULT model: 34-cycle signed multiply; stop is a level that stays high after completion
  // and only drops one cycle after the next start, so a stale level is visible in the first WAIT cycle.
  logic [5:0]  mcnt = '0;
  logic [63:0] prod;
  assign prod = {{32{unit_a[31]}}, unit_a} * {{32{unit_b[31]}}, unit_b};

  always @(posedge clk) begin
    if (!reset) begin
      mcnt <= '0;
    end else if (mult_start) begin
      mcnt <= 6'd34;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 6'd1;
      if (mcnt == 6'd34) mult_stop <= 1'b0;
      if (mcnt == 6'd1) begin
        mult_stop          <= 1'b1;
        {mult_hi, mult_lo} <= prod;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  n, mstarts, dstarts, dones;
  bit  busy_drop;

  initial begin
    reset = 1'b0; op_start = 0; op_sel = 0; hi_wr = 0; lo_wr = 0;
    src_a = '0; src_b = '0; wr_data = '0;
    div_stop = 0; div_hi = '0; div_lo = '0;
    #2;
    check("rst_hi_lo", {hi_out, lo_out}, 64'h0);
    check("rst_unit_ab", {unit_a, unit_b}, 64'h0);
    check("rst_strobes", {busy, done, mult_start, div_start, div_zero, timeout}, 6'b0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // ---- MULT 7 * -3 ----
    op_start = 1; op_sel = 0; src_a = 32'd7; src_b = 32'hFFFF_FFFD;
    tick();
    op_start = 0;
    check("mul_launch_busy", busy, 1'b1);
    check("mul_launch_start", {mult_start, div_start}, 2'b10);
    check("mul_unit_ab", {unit_a, unit_b}, {32'd7, 32'hFFFF_FFFD});
    n = 0; busy_drop = 0; mstarts = 1;
    while (!done && n < 60) begin
      if (!busy) busy_drop = 1;
      tick(); n++;
      mstarts += int'(mult_start);
    end
    check("mul_done_latency", n, 36);
    check("mul_busy_held", busy_drop, 1'b0);
    check("mul_busy_at_done", busy, 1'b1);
    check("mul_start_once", mstarts, 1);
    check("mul_result", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    check("mul_done_pulse", {done, busy}, 2'b00);

    // ---- DIV 100 / 7 with stub (mult_stop stays high, must be ignored) ----
    op_start = 1; op_sel = 1; src_a = 32'd100; src_b = 32'd7;
    tick();
    op_start = 0;
    check("div_launch_start", {mult_start, div_start}, 2'b01);
    dstarts = 1; mstarts = 0; dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      dstarts += int'(div_start); mstarts += int'(mult_start); dones += int'(done);
    end
    check("div_no_early_done", dones, 0);
    div_hi = 32'd2; div_lo = 32'd14; div_stop = 1;
    n = 0;
    while (!done && n < 60) begin
      tick(); n++;
      dstarts += int'(div_start); mstarts += int'(mult_start);
    end
    div_stop = 0;
    check("div_done_latency", n, 1);
    check("div_result", {hi_out, lo_out}, {32'd2, 32'd14});
    check("div_start_once", dstarts, 1);
    check("div_no_mult_start", mstarts, 0);
    tick();

    // ---- MTHI in IDLE ----
    hi_wr = 1; wr_data = 32'hDEAD_BEEF;
    tick();
    hi_wr = 0;
    check("mthi_idle", {hi_out, lo_out}, {32'hDEAD_BEEF, 32'd14});

    // ---- DIV by zero ----
    op_start = 1; op_sel = 1; src_a = 32'd5; src_b = 32'd0;
    tick();
    op_start = 0;
    check("dz_pulse", {div_zero, busy, div_start, mult_start}, 4'b1100);
    check("dz_no_latch", unit_a, 32'd100);
    tick();
    check("dz_end", {div_zero, busy}, 2'b00);
    check("dz_hilo_kept", {hi_out, lo_out}, {32'hDEAD_BEEF, 32'd14});

    // ---- DIV timeout, with an MTLO attempt during WAIT ----
    op_start = 1; op_sel = 1; src_a = 32'd9; src_b = 32'd3;
    tick();
    op_start = 0;
    n = 0; dones = 0;
    while (!timeout && n < 60) begin
      lo_wr = (n == 5); wr_data = 32'h1234_5678;
      tick(); n++;
      dones += int'(done);
      if (n == 20) check("mtlo_in_wait_ignored", lo_out, 32'd14);
    end
    lo_wr = 0;
    check("to_latency", n, 41);
    check("to_no_done", dones, 0);
    check("to_busy_low", busy, 1'b0);
    check("to_hilo_kept", {hi_out, lo_out}, {32'hDEAD_BEEF, 32'd14});
    tick();
    check("to_pulse_one", timeout, 1'b0);

    // ---- MULT 3 * 5 after timeout; stale mult_stop in first WAIT cycle ----
    op_start = 1; op_sel = 0; src_a = 32'd3; src_b = 32'd5;
    tick();
    op_start = 0;
    check("op_after_to", {busy, mult_start}, 2'b11);
    tick();
    check("stale_stop_present", mult_stop, 1'b1);
    tick();
    check("stale_ignored", {done, busy}, 2'b01);
    n = 0;
    while (!done && n < 60) begin tick(); n++; end
    check("mul2_result", {hi_out, lo_out}, 64'd15);
    tick();

    // ---- reset mid-WAIT with stale mult_stop high ----
    op_start = 1; op_sel = 0; src_a = 32'd6; src_b = 32'd7;
    tick();
    op_start = 0;
    tick();
    check("pre_reset_wait", {busy, mult_stop}, 2'b11);
    reset = 1'b0;
    #1;
    check("mid_reset_hilo", {hi_out, lo_out}, 64'h0);
    check("mid_reset_unit", {unit_a, unit_b}, 64'h0);
    check("mid_reset_ctl", {busy, done, mult_start, div_start, div_zero, timeout}, 6'b0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // ---- MULT -1 * 2 with simultaneous MTHI; COMMIT overwrites ----
    op_start = 1; op_sel = 0; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    hi_wr = 1; wr_data = 32'hAAAA_5555;
    tick();
    op_start = 0; hi_wr = 0;
    check("same_cycle_mthi", {hi_out, busy, mult_start}, {32'hAAAA_5555, 2'b11});
    tick();
    check("post_reset_stale", mult_stop, 1'b1);
    tick();
    check("post_reset_stale_ignored", {done, busy}, 2'b01);
    n = 0;
    while (!done && n < 60) begin tick(); n++; end
    check("mul3_done", done, 1'b1);
    check("mul3_result", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("mul3_idle", {done, busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
